// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// vga_sprite_engine -- VGA timing generator and NUM_SPRITES bitmap compositor.
// Optional per-frame sprite motion with edge bounce: VGA_SPRITE_BOUNCE_EN.
// Rev 1.0
// ============================================================================
module vga_sprite_engine #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int CLK_DIV = 2,
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_SIZE = 16,
  parameter logic [2:0] BG_RGB = 3'b111,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int ROW_W = $clog2(SPRITE_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [1:0]             cfg_addr,
  input  logic [15:0]            cfg_wdata,
  input  logic                   bm_we,
  input  logic [SEL_W-1:0]       bm_sel,
  input  logic [ROW_W-1:0]       bm_row,
  input  logic [SPRITE_SIZE-1:0] bm_data,
  output logic                   hsync,
  output logic                   vsync,
  output logic [2:0]             rgb,
  output logic                   video_on,
  output logic                   frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             h_wrap;
  logic [10:0]      h_q, h_d, v_q, v_d;

  always_comb begin
    tick   = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    h_wrap = (h_q == 11'(H_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      h_d = h_wrap ? 11'd0 : h_q + 11'd1;
      if (h_wrap) v_d = (v_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_q + 11'd1;
    end
  end

  // Sprite register file
  logic [NUM_SPRITES-1:0][9:0] x_q, x_d, y_q, y_d;
  logic [NUM_SPRITES-1:0][3:0] hspd_q, hspd_d, vspd_q, vspd_d;
  logic [NUM_SPRITES-1:0][2:0] color_q, color_d;
  logic [NUM_SPRITES-1:0]      hdir_q, hdir_d, vdir_q, vdir_d, en_q, en_d;

  // Bitmap RAM, deliberately not reset so contents survive rst_n
  logic [SPRITE_SIZE-1:0] bm_mem [2**(SEL_W+ROW_W)];

  always_ff @(posedge clk) begin
    if (bm_we) bm_mem[{bm_sel, bm_row}] <= bm_data;
  end

`ifdef VGA_SPRITE_BOUNCE_EN
  localparam logic [9:0] XMAX = 10'(H_DISPLAY - SPRITE_SIZE);
  localparam logic [9:0] YMAX = 10'(V_DISPLAY - SPRITE_SIZE);

  typedef enum logic [0:0] {IDLE = 1'b0, UPDATE = 1'b1} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] k_q, k_d;

  // Returns {dir, pos} after one frame step, clamping at 0 and lim.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic [3:0] spd,
                                         input logic dir, input logic [9:0] lim);
    logic [10:0] p, s, sum;
    p      = {1'b0, pos};
    s      = {7'd0, spd};
    sum    = p + s;
    bounce = {dir, pos};
    if (spd != 4'd0) begin
      if (dir) bounce = (sum >= {1'b0, lim}) ? {1'b0, lim} : {1'b1, sum[9:0]};
      else     bounce = (s >= p) ? {1'b1, 10'd0} : {1'b0, pos - {6'd0, spd}};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (tick && h_wrap && (v_q == 11'(V_DISPLAY - 1))) begin
          state_d = UPDATE;
          k_d     = '0;
        end
      end
      UPDATE: begin
        k_d = k_q + SEL_W'(1);
        if (k_q == SEL_W'(NUM_SPRITES - 1)) begin
          state_d = IDLE;
          k_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  logic unused_cfg;
  assign unused_cfg = ^cfg_wdata[15:10];
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_wdata[15:10], hspd_q, vspd_q, hdir_q, vdir_q};
`endif

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    hspd_d  = hspd_q;
    vspd_d  = vspd_q;
    hdir_d  = hdir_q;
    vdir_d  = vdir_q;
    en_d    = en_q;
    color_d = color_q;
`ifdef VGA_SPRITE_BOUNCE_EN
    if (state_q == UPDATE) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if ((k_q == SEL_W'(i)) && en_q[i]) begin
          {hdir_d[i], x_d[i]} = bounce(x_q[i], hspd_q[i], hdir_q[i], XMAX);
          {vdir_d[i], y_d[i]} = bounce(y_q[i], vspd_q[i], vdir_q[i], YMAX);
        end
      end
    end
`endif
    // CPU writes are applied last so they override the motion result per field
    if (cfg_we) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (cfg_sel == SEL_W'(i)) begin
          case (cfg_addr)
            2'd0: x_d[i] = cfg_wdata[9:0];
            2'd1: y_d[i] = cfg_wdata[9:0];
            2'd2: begin
              vdir_d[i] = cfg_wdata[9];
              hdir_d[i] = cfg_wdata[8];
              vspd_d[i] = cfg_wdata[7:4];
              hspd_d[i] = cfg_wdata[3:0];
            end
            default: begin
              en_d[i]    = cfg_wdata[3];
              color_d[i] = cfg_wdata[2:0];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      hspd_q  <= '0;
      vspd_q  <= '0;
      hdir_q  <= '1;
      vdir_q  <= '1;
      en_q    <= '0;
      color_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hspd_q  <= hspd_d;
      vspd_q  <= vspd_d;
      hdir_q  <= hdir_d;
      vdir_q  <= vdir_d;
      en_q    <= en_d;
      color_q <= color_d;
    end
  end

  logic [NUM_SPRITES-1:0] hit;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [10:0]            x_ext, y_ext;
    logic [ROW_W-1:0]       col, row;
    logic [SPRITE_SIZE-1:0] row_bits;
    logic                   in_x, in_y;
    assign x_ext    = {1'b0, x_q[i]};
    assign y_ext    = {1'b0, y_q[i]};
    assign in_x     = (h_q >= x_ext) && (h_q < x_ext + 11'(SPRITE_SIZE));
    assign in_y     = (v_q >= y_ext) && (v_q < y_ext + 11'(SPRITE_SIZE));
    assign col      = ROW_W'(h_q - x_ext);
    assign row      = ROW_W'(v_q - y_ext);
    assign row_bits = bm_mem[{SEL_W'(i), row}];
    assign hit[i]   = en_q[i] && in_x && in_y && row_bits[col];
  end

  logic [2:0] pix;
  logic       visible;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       video_on_q, video_on_d, frame_start_q, frame_start_d;

  always_comb begin
    pix = BG_RGB;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix = color_q[i];
    end
    visible       = (h_q < 11'(H_DISPLAY)) && (v_q < 11'(V_DISPLAY));
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = tick && (h_q == 11'd0) && (v_q == 11'd0);
    if (tick) begin
      rgb_d      = visible ? pix : 3'd0;
      video_on_d = visible;
      hsync_d    = (h_q >= 11'(HS_START)) && (h_q < 11'(HS_START + H_SYNC));
      vsync_d    = (v_q >= 11'(VS_START)) && (v_q < 11'(VS_START + V_SYNC));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// tb_vga_sprite_engine -- directed checks of raster timing, compositing and
// sprite motion on a reduced 56x37 raster (40x30 visible, 8x8 sprites).
module tb_vga_sprite_engine;
  localparam int HD = 40, HF = 4, HS = 6, HB = 6;
  localparam int VD = 30, VF = 2, VS = 2, VB = 3;
  localparam int DIV = 2, NS = 2, SZ = 8;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLK = DIV * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_sel = '0;
  logic [1:0] cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic       bm_we = 1'b0;
  logic [0:0] bm_sel = '0;
  logic [2:0] bm_row = '0;
  logic [7:0] bm_data = '0;
  logic       hsync, vsync, video_on, frame_start;
  logic [2:0] rgb;

  int n_chk = 0;
  int n_bad = 0;
  logic [5:0] fr [HT*VT];

  vga_sprite_engine #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .NUM_SPRITES(NS), .SPRITE_SIZE(SZ), .BG_RGB(3'b111)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .bm_we(bm_we), .bm_sel(bm_sel), .bm_row(bm_row), .bm_data(bm_data),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int sel, input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = 1'(sel);
    cfg_addr  = 2'(addr);
    cfg_wdata = 16'(data);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic bm_write(input int sel, input int row, input int data);
    bm_we   = 1'b1;
    bm_sel  = 1'(sel);
    bm_row  = 3'(row);
    bm_data = 8'(data);
    @(negedge clk);
    bm_we   = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FRAME_CLK);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  // Record one full frame; entry k holds the outputs for raster position k.
  task automatic capture();
    wait_fs();
    for (int k = 0; k < HT * VT; k++) begin
      if (k > 0) repeat (DIV) @(negedge clk);
      fr[k] = {video_on, hsync, vsync, rgb};
    end
  endtask

  function automatic logic [2:0] rgb_at(input int h, input int v);
    logic [5:0] e;
    e = fr[v * HT + h];
    return e[2:0];
  endfunction

  function automatic logic hs_at(input int h, input int v);
    logic [5:0] e;
    e = fr[v * HT + h];
    return e[4];
  endfunction

  function automatic logic vs_at(input int h, input int v);
    logic [5:0] e;
    e = fr[v * HT + h];
    return e[3];
  endfunction

  initial begin
    int n, hs_cnt, vs_cnt, vo_cnt, rgb_bad;
    logic [5:0] e;

    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_video_on", video_on, 0);
    chk("rst_frame_start", frame_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fs", frame_start, 0);
    @(negedge clk);
    chk("first_fs", frame_start, 1);
    chk("first_video_on", video_on, 1);

    wait_fs();
    @(negedge clk);
    chk("fs_width", frame_start, 0);
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * FRAME_CLK);
    chk("frame_period", n, FRAME_CLK);

    capture();
    hs_cnt = 0; vs_cnt = 0; vo_cnt = 0; rgb_bad = 0;
    for (int k = 0; k < HT * VT; k++) begin
      e = fr[k];
      hs_cnt += int'(e[4]);
      vs_cnt += int'(e[3]);
      vo_cnt += int'(e[5]);
      if (e[2:0] != (e[5] ? 3'b111 : 3'b000)) rgb_bad++;
    end
    chk("hsync_count", hs_cnt, HS * VT);
    chk("vsync_count", vs_cnt, VS * HT);
    chk("video_on_count", vo_cnt, HD * VD);
    chk("bg_rgb_errors", rgb_bad, 0);
    chk("hs_43", hs_at(43, 0), 0);
    chk("hs_44", hs_at(44, 0), 1);
    chk("hs_49", hs_at(49, 3), 1);
    chk("hs_50", hs_at(50, 3), 0);
    chk("vs_31", vs_at(0, 31), 0);
    chk("vs_32", vs_at(0, 32), 1);
    chk("vs_33", vs_at(55, 33), 1);
    chk("vs_34", vs_at(0, 34), 0);
    chk("rgb_39_29", rgb_at(39, 29), 7);
    chk("rgb_40_29", rgb_at(40, 29), 0);
    chk("rgb_0_30", rgb_at(0, 30), 0);

    for (int r = 0; r < SZ; r++) bm_write(0, r, 'hFF);
    bm_write(1, 0, 'h05);
    for (int r = 1; r < SZ; r++) bm_write(1, r, 'h00);
    cfg_write(0, 0, 10); cfg_write(0, 1, 5);  cfg_write(0, 3, 'hC);
    cfg_write(1, 0, 20); cfg_write(1, 1, 20); cfg_write(1, 3, 'hA);
    capture();
    chk("s0_tl", rgb_at(10, 5), 4);
    chk("s0_br", rgb_at(17, 12), 4);
    chk("s0_right_out", rgb_at(18, 5), 7);
    chk("s0_below_out", rgb_at(10, 13), 7);
    chk("s0_left_out", rgb_at(9, 5), 7);
    chk("s1_col0", rgb_at(20, 20), 2);
    chk("s1_col1", rgb_at(21, 20), 7);
    chk("s1_col2", rgb_at(22, 20), 2);
    chk("s1_row1", rgb_at(20, 21), 7);

    for (int r = 0; r < SZ; r++) bm_write(1, r, 'hFF);
    cfg_write(1, 0, 10); cfg_write(1, 1, 5); cfg_write(1, 3, 'hE);
    capture();
    chk("ovl_tl", rgb_at(10, 5), 4);
    chk("ovl_br", rgb_at(17, 12), 4);
    cfg_write(0, 3, 0);
    capture();
    chk("s1_alone", rgb_at(10, 5), 6);
    cfg_write(1, 0, 36); cfg_write(1, 1, 0);
    capture();
    chk("edge_35", rgb_at(35, 0), 7);
    chk("edge_39", rgb_at(39, 0), 6);
    chk("edge_40", rgb_at(40, 0), 0);
    chk("edge_36_7", rgb_at(36, 7), 6);
    chk("edge_36_8", rgb_at(36, 8), 7);

    // Sprite 0's update cycle is the clk after the tick that leaves (55,29);
    // the x write below is timed to land on exactly that clk.
    cfg_write(1, 3, 0);
    wait_fs();
    cfg_write(0, 0, 28); cfg_write(0, 1, 5); cfg_write(0, 2, 'h307); cfg_write(0, 3, 'hC);
    repeat (DIV * (29 * HT + 55) - 4) @(negedge clk);
    cfg_write(0, 0, 10);
`ifdef VGA_SPRITE_BOUNCE_EN
    capture();
    chk("race_x_in", rgb_at(10, 5), 4);
    chk("race_x_out", rgb_at(9, 5), 7);
    capture();
    chk("dirflip_in", rgb_at(3, 5), 4);
    chk("dirflip_out", rgb_at(2, 5), 7);
    capture();
    chk("low_clamp_in", rgb_at(0, 5), 4);
    chk("low_clamp_out", rgb_at(8, 5), 7);
    capture();
    chk("after_low_in", rgb_at(7, 5), 4);
    chk("after_low_out", rgb_at(6, 5), 7);
    cfg_write(0, 0, 28); cfg_write(0, 2, 'h307);
    capture();
    chk("start28_in", rgb_at(28, 5), 4);
    chk("start28_out", rgb_at(27, 5), 7);
    capture();
    chk("hi_clamp_in", rgb_at(32, 5), 4);
    chk("hi_clamp_out", rgb_at(31, 5), 7);
    capture();
    chk("after_hi_in", rgb_at(25, 5), 4);
    chk("after_hi_out", rgb_at(24, 5), 7);
    chk("after_hi_end", rgb_at(33, 5), 7);
`else
    capture();
    chk("static_x_in", rgb_at(10, 5), 4);
    chk("static_x_out", rgb_at(9, 5), 7);
    capture();
    chk("static_x2_in", rgb_at(10, 5), 4);
    chk("static_x2_out", rgb_at(9, 5), 7);
    chk("static_x2_end", rgb_at(18, 5), 7);
`endif

    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rgb", rgb, 0);
    chk("midrst_video_on", video_on, 0);
    chk("midrst_hsync", hsync, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_post_fs", frame_start, 0);
    @(negedge clk);
    chk("midrst_first_fs", frame_start, 1);
    cfg_write(0, 0, 10); cfg_write(0, 1, 5); cfg_write(0, 3, 'hC);
    capture();
    chk("bm_kept_in", rgb_at(10, 5), 4);
    chk("bm_kept_out", rgb_at(9, 5), 7);
    chk("s1_reset_off", rgb_at(36, 0), 7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
